// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit IDs, wormhole TX FSM states and width helpers.
package noc_pkg;

    localparam logic [1:0] FLIT_ID_HEAD = 2'b01;
    localparam logic [1:0] FLIT_ID_BODY = 2'b10;
    localparam logic [1:0] FLIT_ID_TAIL = 2'b11;

    typedef enum logic {
        WH_TX_IDLE,
        WH_TX_BODY
    } wh_tx_state_e;

    function automatic int unsigned FLIT_W(input int unsigned data_w, input int unsigned id_w);
        return data_w + id_w;
    endfunction

    // Bits of the head flit data field occupied by {row, col, hop}.
    function automatic int unsigned CALC_DATA_RANGE(input int unsigned row_w,
                                                    input int unsigned col_w,
                                                    input int unsigned hop_w);
        return row_w + col_w + hop_w;
    endfunction

endpackage

// File: rtl/wh_tx_out_reg.sv
// Single-entry valid/ready output register; ld_o tells the producer when a new flit may be loaded.
module wh_tx_out_reg #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ld_o
);

    assign ld_o = !vld_o || rdy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_o  <= 1'b0;
            data_o <= '0;
        end else if (ld_o) begin
            vld_o <= load_i;
            if (load_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/mesh_wormhole_tx.sv
// Packet-to-flit serializer: HEAD, then BODY flits, then TAIL onto a mesh node local port.
// Optional checks are compiled in with `define WH_TX_ASSERT_EN.
module mesh_wormhole_tx
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_DATA_W = 8,
    parameter int unsigned FLIT_ID_W   = 2,
    parameter int unsigned HOP_CNT_W   = 4,
    parameter int unsigned ROW_ADDR_W  = 2,
    parameter int unsigned COL_ADDR_W  = 2,
    parameter int unsigned PKT_LEN_W   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [ROW_ADDR_W-1:0]            pkt_row_i,
    input  logic [COL_ADDR_W-1:0]            pkt_col_i,
    input  logic [PKT_LEN_W-1:0]             pkt_len_i,
    input  logic                             pkt_vld_i,
    output logic                             pkt_rdy_o,
    input  logic [FLIT_DATA_W-1:0]           pay_data_i,
    input  logic                             pay_vld_i,
    output logic                             pay_rdy_o,
    output logic [FLIT_DATA_W+FLIT_ID_W-1:0] out_chan_data_o,
    output logic                             out_chan_vld_o,
    input  logic                             out_chan_rdy_i
);

    localparam int unsigned OUT_W = FLIT_W(FLIT_DATA_W, FLIT_ID_W);

    wh_tx_state_e           state;
    logic [PKT_LEN_W-1:0]   rem;
    logic                   ld;
    logic                   cmd_acc;
    logic                   pay_acc;
    logic                   last;
    logic [PKT_LEN_W-1:0]   len_eff;
    logic [FLIT_DATA_W-1:0] head_data;
    logic [OUT_W-1:0]       load_flit;

    assign pkt_rdy_o = (state == WH_TX_IDLE) && ld;
    assign pay_rdy_o = (state == WH_TX_BODY) && ld;
    assign cmd_acc   = pkt_vld_i && pkt_rdy_o;
    assign pay_acc   = pay_vld_i && pay_rdy_o;
    assign last      = (rem == PKT_LEN_W'(1));
    // A zero length is folded to one so the worm is always closed by a TAIL.
    assign len_eff   = (pkt_len_i == '0) ? PKT_LEN_W'(1) : pkt_len_i;

    always_comb begin
        head_data = '0;
        head_data[HOP_CNT_W +: COL_ADDR_W]              = pkt_col_i;
        head_data[HOP_CNT_W+COL_ADDR_W +: ROW_ADDR_W]   = pkt_row_i;
    end

    always_comb begin
        load_flit = '0;
        if (state == WH_TX_IDLE) begin
            load_flit = {FLIT_ID_W'(FLIT_ID_HEAD), head_data};
        end else begin
            load_flit = {(last ? FLIT_ID_W'(FLIT_ID_TAIL) : FLIT_ID_W'(FLIT_ID_BODY)), pay_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= WH_TX_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                WH_TX_IDLE: begin
                    if (cmd_acc) begin
                        rem   <= len_eff;
                        state <= WH_TX_BODY;
                    end
                end
                WH_TX_BODY: begin
                    if (pay_acc) begin
                        rem <= rem - PKT_LEN_W'(1);
                        if (last) begin
                            state <= WH_TX_IDLE;
                        end
                    end
                end
                default: state <= WH_TX_IDLE;
            endcase
        end
    end

    wh_tx_out_reg #(
        .WIDTH (OUT_W)
    ) u_out_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (cmd_acc || pay_acc),
        .data_i (load_flit),
        .rdy_i  (out_chan_rdy_i),
        .vld_o  (out_chan_vld_o),
        .data_o (out_chan_data_o),
        .ld_o   (ld)
    );

`ifdef WH_TX_ASSERT_EN
    if (CALC_DATA_RANGE(ROW_ADDR_W, COL_ADDR_W, HOP_CNT_W) > FLIT_DATA_W) begin : g_bad_head_fit
        $error("mesh_wormhole_tx: row+col+hop fields exceed FLIT_DATA_W");
    end

    a_len_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cmd_acc |-> (pkt_len_i != '0))
        else $error("mesh_wormhole_tx: zero-length packet command accepted");

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_chan_vld_o && !out_chan_rdy_i) |=> ($stable(out_chan_data_o) && out_chan_vld_o))
        else $error("mesh_wormhole_tx: output changed or dropped without handshake");

    a_no_null_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_chan_vld_o |-> (out_chan_data_o[OUT_W-1 -: FLIT_ID_W] != '0))
        else $error("mesh_wormhole_tx: flit with id 0 emitted");
`endif

endmodule

// File: tb/tb_mesh_wormhole_tx.sv
// Self-checking bench for mesh_wormhole_tx: flit-list model plus directed scenarios.
module tb_mesh_wormhole_tx;

    localparam int HOP_W = 4;
    localparam int COL_W = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pkt_row, pkt_col;
    logic [3:0] pkt_len;
    logic       pkt_vld, pkt_rdy;
    logic [7:0] pay_data;
    logic       pay_vld, pay_rdy;
    logic [9:0] out_data;
    logic       out_vld, out_rdy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [9:0] exp_q[$];
    int         hs_cyc[$];

    logic       load_pend = 1'b0;
    logic       stall_prev = 1'b0;
    logic [9:0] prev_data = '0;
    logic [9:0] exp_flit;

    mesh_wormhole_tx #(
        .FLIT_DATA_W (8),
        .FLIT_ID_W   (2),
        .HOP_CNT_W   (4),
        .ROW_ADDR_W  (2),
        .COL_ADDR_W  (2),
        .PKT_LEN_W   (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pkt_row_i       (pkt_row),
        .pkt_col_i       (pkt_col),
        .pkt_len_i       (pkt_len),
        .pkt_vld_i       (pkt_vld),
        .pkt_rdy_o       (pkt_rdy),
        .pay_data_i      (pay_data),
        .pay_vld_i       (pay_vld),
        .pay_rdy_o       (pay_rdy),
        .out_chan_data_o (out_data),
        .out_chan_vld_o  (out_vld),
        .out_chan_rdy_i  (out_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output-side checker: every flit must match the expected list, in order.
    initial begin : cmp
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                load_pend  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (load_pend) begin
                    chk("load_latency_vld", 32'(out_vld), 32'd1);
                    if (exp_q.size() > 0) chk("load_latency_data", 32'(out_data), 32'(exp_q[0]));
                end
                if (stall_prev) begin
                    chk("hold_vld", 32'(out_vld), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (out_vld && exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_flit actual=%0h required=none", out_data);
                end
                if (out_vld && out_rdy && exp_q.size() > 0) begin
                    exp_flit = exp_q.pop_front();
                    chk("flit", 32'(out_data), 32'(exp_flit));
                    hs_cyc.push_back(cyc);
                end
                load_pend  = (pkt_vld && pkt_rdy) || (pay_vld && pay_rdy);
                stall_prev = out_vld && !out_rdy;
                prev_data  = out_data;
            end
        end
    end

    task automatic wait_hs(input bit is_cmd, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (is_cmd ? pkt_rdy : pay_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_pkt_rdy"}, 32'(pkt_rdy), 32'd1);
        chk({tag, "_pay_rdy"}, 32'(pay_rdy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_reset_vals("reset_mid");
        exp_q.delete();
        pkt_vld = 1'b0;
        pay_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_packet(input int row, input int col, input int len, input logic [7:0] base,
                             input logic [9:0] head_pin, input int bp_idx, input int bp_len,
                             input int st_idx, input int st_len, input int rst_idx);
        int n;
        bit ok;
        n = (len == 0) ? 1 : len;
        exp_q.push_back({2'b01, 8'((row << (HOP_W + COL_W)) | (col << HOP_W))});
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1) ? 2'b11 : 2'b10, 8'(base + 8'(i))});
        pkt_row = 2'(row);
        pkt_col = 2'(col);
        pkt_len = 4'(len);
        pkt_vld = 1'b1;
        wait_hs(1'b1, ok);
        chk("cmd_handshake", 32'(ok), 32'd1);
        pkt_vld = 1'b0;
        if (head_pin != '0) chk("head_literal", 32'(out_data), 32'(head_pin));
        for (int i = 0; i < n; i++) begin
            if (i == rst_idx) begin
                do_reset();
                return;
            end
            if (i == st_idx) begin
                pay_vld = 1'b0;
                for (int s = 0; s < st_len; s++) begin
                    @(negedge clk);
                    if (s >= 1) chk("bubble_vld_low", 32'(out_vld), 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
            pay_data = base + 8'(i);
            pay_vld  = 1'b1;
            if (i == bp_idx) begin
                out_rdy = 1'b0;
                for (int b = 0; b < bp_len; b++) begin
                    @(negedge clk);
                    chk("bp_pay_rdy_low", 32'(pay_rdy), 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_rdy = 1'b1;
            end
            wait_hs(1'b0, ok);
            chk("pay_handshake", 32'(ok), 32'd1);
        end
        pay_vld = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        pkt_row  = '0;
        pkt_col  = '0;
        pkt_len  = '0;
        pkt_vld  = 1'b0;
        pay_data = '0;
        pay_vld  = 1'b0;
        out_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_out_vld", 32'(out_vld), 32'd0);
            chk("idle_pkt_rdy", 32'(pkt_rdy), 32'd1);
            chk("idle_pay_rdy", 32'(pay_rdy), 32'd0);
        end
        @(posedge clk);
        #1;

        // row=2,col=1: head data 1001_0000
        hs_cyc.delete();
        do_packet(2, 1, 3, 8'hA1, 10'h190, -1, 0, -1, 0, -1);
        drain();
        chk("single_flit_count", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) chk("single_consecutive", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);

        do_packet(3, 3, 1, 8'h5C, 10'h1F0, -1, 0, -1, 0, -1);
        drain();
        @(negedge clk);
        chk("len1_pkt_rdy", 32'(pkt_rdy), 32'd1);
        @(posedge clk);
        #1;

        do_packet(1, 2, 5, 8'h30, 10'h0, 2, 5, -1, 0, -1);
        drain();

        do_packet(0, 3, 4, 8'h40, 10'h0, -1, 0, 2, 3, -1);
        drain();

        hs_cyc.delete();
        do_packet(1, 1, 2, 8'h50, 10'h150, -1, 0, -1, 0, -1);
        do_packet(2, 2, 2, 8'h60, 10'h1A0, -1, 0, -1, 0, 1);
        chk("b2b_first_flits_seen", 32'(hs_cyc.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals("post_reset");
        end
        @(posedge clk);
        #1;

        do_packet(0, 1, 2, 8'h70, 10'h110, -1, 0, -1, 0, -1);
        drain();

`ifndef WH_TX_ASSERT_EN
        // Zero length behaves as a one-flit payload.
        do_packet(1, 0, 0, 8'h7E, 10'h140, -1, 0, -1, 0, -1);
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
